// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop serialiser.
// Bytes leave LSB first on a registered tx line at CLK_HZ/BAUD clocks per bit.
module uart_transmit #(
    parameter int CLK_HZ     = 5_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int TMR_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYC - 1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   level_q, level_d;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             txDone_q, txDone_d;

    logic push;
    logic pop;
    logic bitEnd;
    logic canPop;

    assign ready  = (level_q != LVL_FULL);
    assign push   = valid && ready;
    assign canPop = (level_q != '0);
    assign bitEnd = (timer_q == TMR_LAST);

    // The line only ever reads the shift register, so later pushes cannot disturb a frame.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TMR_W'(1);
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        txDone_d = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (canPop) begin
                    pop     = 1'b1;
                    shift_d = mem[rdPtr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bitEnd) begin
                    timer_d  = '0;
                    state_d  = DATA;
                    bitIdx_d = 3'd0;
                    tx_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    timer_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        tx_d     = shift_q[bitIdx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bitEnd) begin
                    timer_d  = '0;
                    txDone_d = 1'b1;
                    if (canPop) begin
                        pop     = 1'b1;
                        shift_d = mem[rdPtr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wrPtr_q] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            timer_q  <= '0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            txDone_q <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            txDone_q <= txDone_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = txDone_q;
    assign level   = level_q;
    assign busy    = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: a driver queues each accepted byte with its accept cycle,
// and a line decoder rebuilds frames from tx and checks them against that queue.
module tb_uart_transmit;

    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 43_000;
    localparam int DEPTH   = 4;
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int FRAME   = 10 * BIT_CYC;

    typedef struct {
        logic [7:0] b;
        int         acc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [2:0] level;

    int   cyc = 0;
    logic rstEdge = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   framesDone = 0;
    int   expectedFrames = 0;
    exp_t sbQ[$];

    uart_transmit #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy),
        .tx_done(tx_done),
        .level  (level)
    );

    always #5 clock = ~clock;

    // Edge counter and a record of whether the most recent edge saw reset.
    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rstEdge <= reset;
    end

    always @(negedge clock) begin
        if (tx_done === 1'b1) pulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Caller is at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic applyStimulus(input logic [7:0] b, output int accCyc);
        int waited = 0;
        valid   = 1'b1;
        data_in = b;
        accCyc  = -1;
        while (accCyc < 0) begin
            if (ready === 1'b1 && !reset) begin
                accCyc = cyc + 1;
                sbQ.push_back('{b, accCyc});
                expectedFrames++;
                @(negedge clock);
            end else begin
                if (!reset) checkOutput("level_full_while_not_ready", 32'(level), DEPTH);
                @(negedge clock);
                waited++;
                if (waited > 2 * FRAME) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL accept_timeout byte=%0h cycle=%0d", b, cyc);
                    valid = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic idleCycles(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic waitIdle();
        int waited = 0;
        valid = 1'b0;
        while ((sbQ.size() != 0 || busy !== 1'b0) && waited < (DEPTH + 3) * FRAME) begin
            @(negedge clock);
            waited++;
        end
        if (sbQ.size() != 0 || busy !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout pending=%0d busy=%0b", sbQ.size(), busy);
        end
        @(negedge clock);
    endtask

    // Line decoder: samples each bit mid-slot and checks start time, bits, stop and tx_done.
    initial begin : monitor
        bit         inFrame;
        bit         doneEarly;
        int         fallCyc;
        int         lastEnd;
        int         off;
        int         k;
        logic       prevTx;
        logic [7:0] rxByte;
        exp_t       head;
        inFrame = 0;
        doneEarly = 0;
        fallCyc = 0;
        lastEnd = 0;
        prevTx = 1'b1;
        rxByte = 8'd0;
        forever begin
            @(negedge clock);
            if (rstEdge) begin
                inFrame = 0;
                prevTx  = 1'b1;
                continue;
            end
            if (inFrame) begin
                off = cyc - fallCyc;
                if (off < FRAME) begin
                    if (off % BIT_CYC == BIT_CYC / 2) begin
                        k = off / BIT_CYC;
                        if (k == 0) checkOutput("start_bit", 32'(tx), 0);
                        else if (k <= 8) rxByte[k-1] = tx;
                        else checkOutput("stop_bit", 32'(tx), 1);
                    end
                    if (off > 0 && tx_done !== 1'b0) doneEarly = 1;
                end else begin
                    checkOutput("tx_done_at_frame_end", 32'(tx_done), 1);
                    checkOutput("tx_done_inside_frame", 32'(doneEarly), 0);
                    framesDone++;
                    lastEnd = cyc;
                    inFrame = 0;
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_byte actual=%0h expected=none", rxByte);
                    end else begin
                        head = sbQ.pop_front();
                        checkOutput("data_byte", 32'(rxByte), 32'(head.b));
                    end
                end
            end
            if (!inFrame && tx === 1'b0 && prevTx === 1'b1) begin
                inFrame   = 1;
                fallCyc   = cyc;
                doneEarly = 0;
                rxByte    = 8'd0;
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious_frame cycle=%0d expected=no start", cyc);
                end else begin
                    checkOutput("start_time", 32'(cyc), 32'(maxInt(sbQ[0].acc + 1, lastEnd)));
                end
            end
            prevTx = tx;
        end
    end

    initial begin : driver
        int         acc;
        int         accs[6];
        logic [7:0] burst[6];
        int         target;
        int         pulsesBefore;
        int         nRand;
        burst   = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
        reset   = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clock);
        checkOutput("reset_tx", 32'(tx), 1);
        checkOutput("reset_ready", 32'(ready), 1);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_level", 32'(level), 0);
        checkOutput("reset_tx_done", 32'(tx_done), 0);
        reset = 1'b0;
        idleCycles(2);

        applyStimulus(8'h55, acc);
        valid = 1'b0;
        checkOutput("single_tx_before_start", 32'(tx), 1);
        checkOutput("single_level_after_push", 32'(level), 1);
        checkOutput("single_busy", 32'(busy), 1);
        @(negedge clock);
        checkOutput("single_tx_low_after_1", 32'(tx), 0);
        checkOutput("single_level_after_pop", 32'(level), 0);
        waitIdle();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(burst[i], accs[i]);
            if (i == 4) begin
                checkOutput("burst_ready_low_when_full", 32'(ready), 0);
                checkOutput("burst_level_full", 32'(level), DEPTH);
            end
        end
        valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            checkOutput("burst_accept_immediate", 32'(accs[i]), 32'(accs[0] + i));
        end
        checkOutput("burst_accept_after_pop", 32'(accs[5]), 32'(accs[0] + FRAME + 2));
        waitIdle();

        applyStimulus(8'hC3, acc);
        target = acc + 1 + 4 * BIT_CYC + BIT_CYC / 2;
        applyStimulus(8'h11, accs[0]);
        applyStimulus(8'h22, accs[1]);
        valid = 1'b0;
        while (cyc < target) @(negedge clock);
        checkOutput("c3_data_bit3", 32'(tx), 0);
        pulsesBefore = pulses;
        reset   = 1'b1;
        valid   = 1'b1;
        data_in = 8'h99;
        @(negedge clock);
        checkOutput("midreset_tx", 32'(tx), 1);
        checkOutput("midreset_level", 32'(level), 0);
        checkOutput("midreset_ready", 32'(ready), 1);
        checkOutput("midreset_busy", 32'(busy), 0);
        expectedFrames -= sbQ.size();
        sbQ.delete();
        reset = 1'b0;
        idleCycles(FRAME + 5);
        checkOutput("midreset_no_tx_done", 32'(pulses), 32'(pulsesBefore));
        checkOutput("midreset_line_idle", 32'(tx), 1);
        applyStimulus(8'h3C, acc);
        valid = 1'b0;
        waitIdle();

        nRand = 30;
        for (int i = 0; i < nRand; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), acc);
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, FRAME + 40));
        end
        valid = 1'b0;
        waitIdle();

        checkOutput("end_tx", 32'(tx), 1);
        checkOutput("end_ready", 32'(ready), 1);
        checkOutput("end_level", 32'(level), 0);
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_frames", 32'(framesDone), 32'(expectedFrames));
        checkOutput("end_tx_done_count", 32'(pulses), 32'(framesDone));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
